// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding,
// default bus widths and the burst counter helper.
package dmem_arbiter_pkg;

  // Owner of the most recent grant.
  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Default widths, shared with the data memory and the top level.
  localparam int unsigned DMEM_ADDR_W = 6;
  localparam int unsigned DMEM_DATA_W = 32;

  // Width of the debug burst counter.
  localparam int unsigned BURST_CNT_W = 4;

  // Saturating increment of the burst counter.
  function automatic logic [BURST_CNT_W-1:0] burst_inc(input logic [BURST_CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the data memory and the arbiter.
// slave  : arbiter view (requests in, grants/read data/memory controls out)
// master : environment view (requesters plus the memory)
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
);

  // CPU load/store port
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  // Debug/loader port
  logic              d_req;
  logic              d_we;
  logic              d_lock;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // Data memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Status
  logic              busy;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_lock, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata,
    output busy
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_lock, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// req[0]/gnt[0] = C port, req[1]/gnt[1] = D port.
// On a tie the port opposite to 'last' wins, unless 'lock' keeps D.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  input  logic       lock,
  output logic [1:0] gnt
);

  // One-hot (or zero) grant from the current requests and history.
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (lock || (last == OWN_C)) begin
          gnt = 2'b10;
        end else begin
          gnt = 2'b01;
        end
      end
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the CPU
// load/store path (C) and a debug/loader port (D). Round-robin on ties,
// bounded D burst lock, registered read return with a one-cycle strobe.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = DMEM_ADDR_W,
  parameter int unsigned DATA_W    = DMEM_DATA_W,
  parameter int unsigned MAX_BURST = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [BURST_CNT_W-1:0] BURST_LIM = BURST_CNT_W'(MAX_BURST);

  owner_e                 last;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic                   rvalid_c;
  logic                   rvalid_d;
  logic [DATA_W-1:0]      rdata_c;
  logic [DATA_W-1:0]      rdata_d;

  logic                   lock;
  logic [1:0]             req;
  logic [1:0]             gnt;
  logic                   c_gnt;
  logic                   d_gnt;
  logic                   c_rd;
  logic                   d_rd;
  logic [ADDR_W-1:0]      addr_sel;
  logic [DATA_W-1:0]      wdata_sel;

  // D keeps a tie while its locked burst is still below the limit.
  assign lock = (last == OWN_D) && (burst_cnt != '0) && (burst_cnt < BURST_LIM);

  // Requests are masked while reset is held so that nothing is granted
  // and no write can reach the memory edge during reset.
  assign req = {bus.d_req, bus.c_req} & {2{reset}};

  rr_pick2 u_pick (
    .req  (req),
    .last (last),
    .lock (lock),
    .gnt  (gnt)
  );

  assign c_gnt = gnt[0];
  assign d_gnt = gnt[1];
  assign c_rd  = c_gnt && !bus.c_we;
  assign d_rd  = d_gnt && !bus.d_we;

  // Memory address/data come from the granted port, C when idle.
  always_comb begin
    if (d_gnt) begin
      addr_sel  = bus.d_addr;
      wdata_sel = bus.d_wdata;
    end else begin
      addr_sel  = bus.c_addr;
      wdata_sel = bus.c_wdata;
    end
  end

  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.mem_we    = (c_gnt & bus.c_we) | (d_gnt & bus.d_we);
  assign bus.busy      = c_gnt | d_gnt;
  assign bus.c_gnt     = c_gnt;
  assign bus.d_gnt     = d_gnt;

  // Arbitration history: last owner and locked-burst length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last      <= OWN_D;
      burst_cnt <= '0;
    end else if (c_gnt) begin
      last      <= OWN_C;
      burst_cnt <= '0;
    end else if (d_gnt) begin
      last      <= OWN_D;
      burst_cnt <= bus.d_lock ? burst_inc(burst_cnt) : '0;
    end
  end

  // Registered read return; the strobe lasts one cycle, data holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_c <= 1'b0;
      rvalid_d <= 1'b0;
      rdata_c  <= '0;
      rdata_d  <= '0;
    end else begin
      rvalid_c <= c_rd;
      rvalid_d <= d_rd;
      if (c_rd) begin
        rdata_c <= bus.mem_rdata;
      end
      if (d_rd) begin
        rdata_d <= bus.mem_rdata;
      end
    end
  end

  assign bus.c_rvalid = rvalid_c;
  assign bus.c_rdata  = rdata_c;
  assign bus.d_rvalid = rvalid_d;
  assign bus.d_rdata  = rdata_d;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [31:0] mem [64];

  dmem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single-port memory: synchronous write, combinational read.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_lock = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.c_gnt, bus.d_gnt, bus.busy, bus.mem_we, bus.c_rvalid, bus.d_rvalid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.c_gnt, bus.d_gnt, bus.busy, bus.mem_we, bus.c_rvalid, bus.d_rvalid});
    end
    n_checks++;
    if ({bus.c_rdata, bus.d_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h expected 0", {bus.c_rdata, bus.d_rdata});
    end
    n_checks++;
    if (dut.last !== OWN_D) begin
      n_fail++;
      $display("FAIL reset_last: got %0d expected 1", dut.last);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.c_gnt, bus.d_gnt, bus.busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_grants: got %b expected 000", {bus.c_gnt, bus.d_gnt, bus.busy});
    end
    tick();
    bus.c_req = 1'b1; bus.c_addr = 6'd5;
    @(negedge clk);
    n_checks++;
    if ({bus.c_gnt, bus.d_gnt, bus.busy, bus.mem_addr} !== {3'b101, 6'd5}) begin
      n_fail++;
      $display("FAIL first_c_gnt: got %b expected 101000101",
               {bus.c_gnt, bus.d_gnt, bus.busy, bus.mem_addr});
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({bus.c_rvalid, bus.c_rdata} !== {1'b1, 32'hA000_0005}) begin
      n_fail++;
      $display("FAIL first_c_read: got %b/%h expected 1/a0000005", bus.c_rvalid, bus.c_rdata);
    end
    tick();
  endtask

  task automatic test_cpu_write_read();
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 6'd3; bus.c_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if ({bus.c_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 6'd3, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL cpu_write: got gnt=%b we=%b addr=%0d wdata=%h expected 1 1 3 deadbeef",
               bus.c_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    bus.c_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.c_gnt, bus.mem_we, bus.c_rvalid} !== 3'b100) begin
      n_fail++;
      $display("FAIL cpu_read_cycle: got %b expected 100", {bus.c_gnt, bus.mem_we, bus.c_rvalid});
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({bus.c_rvalid, bus.c_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL cpu_read_data: got %b/%h expected 1/deadbeef", bus.c_rvalid, bus.c_rdata);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.c_rvalid, bus.c_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL cpu_rdata_hold: got %b/%h expected 0/deadbeef", bus.c_rvalid, bus.c_rdata);
    end
    tick();
  endtask

  task automatic test_tie_rr();
    logic exp_c;
    pulse_reset();
    bus.c_req = 1'b1; bus.c_addr = 6'd1;
    bus.d_req = 1'b1; bus.d_addr = 6'd2; bus.d_lock = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_c = ((i % 2) == 0);
      @(negedge clk);
      n_checks++;
      if ({bus.c_gnt, bus.d_gnt} !== {exp_c, ~exp_c}) begin
        n_fail++;
        $display("FAIL tie_rr[%0d]: got c/d=%b%b expected %b%b", i, bus.c_gnt, bus.d_gnt, exp_c, ~exp_c);
      end
      n_checks++;
      if (bus.mem_addr !== (exp_c ? 6'd1 : 6'd2)) begin
        n_fail++;
        $display("FAIL tie_addr[%0d]: got %0d expected %0d", i, bus.mem_addr, exp_c ? 1 : 2);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_burst_lock();
    logic [7:0]  seq;
    logic        exp_d;
    logic        prev_d;
    logic [31:0] prev_data;
    int unsigned k;
    seq = 8'b1101_1110;  // bit i: D expected in cycle i
    prev_d = 1'b0;
    prev_data = '0;
    k = 0;
    pulse_reset();
    bus.c_req = 1'b1; bus.c_addr = 6'd20;
    bus.d_req = 1'b1; bus.d_lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_d = seq[i];
      bus.d_addr = 6'(k);
      @(negedge clk);
      n_checks++;
      if ({bus.c_gnt, bus.d_gnt} !== {~exp_d, exp_d}) begin
        n_fail++;
        $display("FAIL burst_gnt[%0d]: got c/d=%b%b expected %b%b", i, bus.c_gnt, bus.d_gnt, ~exp_d, exp_d);
      end
      n_checks++;
      if (bus.d_rvalid !== prev_d) begin
        n_fail++;
        $display("FAIL burst_rvalid[%0d]: got %b expected %b", i, bus.d_rvalid, prev_d);
      end
      if (prev_d) begin
        n_checks++;
        if (bus.d_rdata !== prev_data) begin
          n_fail++;
          $display("FAIL burst_rdata[%0d]: got %h expected %h", i, bus.d_rdata, prev_data);
        end
      end
      prev_d = exp_d;
      if (exp_d) begin
        prev_data = (k == 3) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(k);
        k++;
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_write_read_collide();
    pulse_reset();
    bus.c_req = 1'b1; bus.c_addr = 6'd11;
    tick();
    bus.c_addr = 6'd10;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 6'd10; bus.d_wdata = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if ({bus.c_gnt, bus.d_gnt, bus.mem_we, bus.mem_addr} !== {3'b011, 6'd10}) begin
      n_fail++;
      $display("FAIL collide_gnt: got c=%b d=%b we=%b addr=%0d expected 0 1 1 10",
               bus.c_gnt, bus.d_gnt, bus.mem_we, bus.mem_addr);
    end
    n_checks++;
    if (bus.mem_wdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL collide_wdata: got %h expected 12345678", bus.mem_wdata);
    end
    n_checks++;
    if ({bus.c_rvalid, bus.c_rdata} !== {1'b1, 32'hA000_000B}) begin
      n_fail++;
      $display("FAIL collide_prev_read: got %b/%h expected 1/a000000b", bus.c_rvalid, bus.c_rdata);
    end
    tick();
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.c_gnt, bus.d_gnt, bus.d_rvalid, bus.mem_we} !== 4'b1000) begin
      n_fail++;
      $display("FAIL collide_c_turn: got %b expected 1000", {bus.c_gnt, bus.d_gnt, bus.d_rvalid, bus.mem_we});
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({bus.c_rvalid, bus.c_rdata} !== {1'b1, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL collide_c_data: got %b/%h expected 1/12345678", bus.c_rvalid, bus.c_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    pulse_reset();
    bus.c_req = 1'b1; bus.c_addr = 6'd20;
    bus.d_req = 1'b1; bus.d_lock = 1'b1;
    // cycle 0: C wins the first tie, cycles 1..2: locked D reads of 0 and 1
    for (int i = 0; i < 3; i++) begin
      bus.d_addr = (i == 0) ? 6'd0 : 6'(i - 1);
      tick();
    end
    bus.d_addr = 6'd2;
    #1;
    n_checks++;
    if ({bus.d_gnt, bus.d_rvalid, dut.burst_cnt} !== {2'b11, 4'd2}) begin
      n_fail++;
      $display("FAIL midburst_pre: got gnt=%b rvalid=%b cnt=%0d expected 1 1 2",
               bus.d_gnt, bus.d_rvalid, dut.burst_cnt);
    end
    #1;
    reset = 1'b0;
    bus.d_we = 1'b1; bus.d_wdata = 32'hBAD0_BAD0;
    #1;
    n_checks++;
    if ({bus.d_rvalid, dut.burst_cnt, dut.last} !== {1'b0, 4'd0, OWN_D}) begin
      n_fail++;
      $display("FAIL midburst_clear: got rvalid=%b cnt=%0d last=%0d expected 0 0 1",
               bus.d_rvalid, dut.burst_cnt, dut.last);
    end
    n_checks++;
    if ({bus.c_gnt, bus.d_gnt, bus.mem_we, bus.busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midburst_gnt: got %b expected 0000", {bus.c_gnt, bus.d_gnt, bus.mem_we, bus.busy});
    end
    tick();
    n_checks++;
    if (mem[2] !== 32'hA000_0002) begin
      n_fail++;
      $display("FAIL midburst_no_write: got %h expected a0000002", mem[2]);
    end
    bus.d_we = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.c_gnt, bus.d_gnt, bus.d_rvalid} !== 3'b100) begin
      n_fail++;
      $display("FAIL after_reset_tie: got %b expected 100", {bus.c_gnt, bus.d_gnt, bus.d_rvalid});
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    test_tie_rr();
    test_burst_lock();
    test_write_read_collide();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU load/store path (C port) and a debug/loader port (D port).
- Grants at most one access per cycle, using round-robin between the two ports.
- The D port may lock the memory for a bounded burst of accesses.
- Read data is returned one cycle after the grant, registered, with a valid strobe. The CPU uses the C-port grant as its stall condition.

Parameters:
- ADDR_W, 6, word address width into data memory.
- DATA_W, 32, data width.
- MAX_BURST, 4, maximum consecutive D-port grants while d_lock is held and C is waiting; range 1..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- c_req  input  1  CPU requests an access this cycle
- c_we  input  1  CPU access is a write
- c_addr  input  ADDR_W  CPU word address
- c_wdata  input  DATA_W  CPU write data
- c_gnt  output  1  CPU access performed this cycle (combinational)
- c_rvalid  output  1  c_rdata valid (cycle after a granted CPU read)
- c_rdata  output  DATA_W  registered CPU read data
- d_req  input  1  debug port requests an access
- d_we  input  1  debug access is a write
- d_lock  input  1  debug asks to keep ownership for the following cycle
- d_addr  input  ADDR_W  debug word address
- d_wdata  input  DATA_W  debug write data
- d_gnt  output  1  debug access performed this cycle (combinational)
- d_rvalid  output  1  d_rdata valid
- d_rdata  output  DATA_W  registered debug read data
- mem_addr  output  ADDR_W  address to data memory
- mem_wdata  output  DATA_W  write data to data memory
- mem_we  output  1  write enable to data memory (memory writes on clk edge)
- mem_rdata  input  DATA_W  combinational read data from data memory
- busy  output  1  some grant is active this cycle

Behaviour:
- State registers:
  - last: 1 bit, 0=C, 1=D.
  - burst_cnt: 4 bits.
  - rvalid_c, rvalid_d.
  - rdata_c, rdata_d.
- Reset (reset==0, asynchronous): last=D, burst_cnt=0, c_rvalid=d_rvalid=0, c_rdata=d_rdata=0. Grants are then a function of inputs only, so they are 0 while neither port requests.
- Grant (combinational, same cycle as the request):
  - Only c_req: C is granted.
  - Only d_req: D is granted.
  - Both, with burst lock active (last==D, d_lock==1 in the previous D cycle, burst_cnt<MAX_BURST): D is granted.
  - Both, otherwise: the port opposite to last is granted.
  - c_gnt and d_gnt are never both 1.
- Memory mux:
  - mem_addr and mem_wdata come from the granted port; C is selected when no port is granted.
  - mem_we = (c_gnt&c_we) | (d_gnt&d_we).
  - busy = c_gnt | d_gnt.
- Edge update:
  - On any grant, last is set to the granted port.
  - burst_cnt on a D grant with d_lock: increments, saturating at 15.
  - burst_cnt on any C grant, or a D grant without d_lock: cleared to 0.
  - burst_cnt with no grant: holds.
  - The lock flag is last==D && burst_cnt!=0.
- Read return:
  - On a granted read (we=0), the port's rdata is loaded with mem_rdata, and its rvalid is 1 in the next cycle only.
  - Granted writes produce no rvalid.
  - rdata holds its value until the next granted read on that port.
- Lock expiry: when burst_cnt reaches MAX_BURST and C is waiting, C wins the next tie; the counter then clears.
- MAX_BURST=1 degenerates to plain round-robin.
- Starvation: with both ports requesting continuously, C waits at most MAX_BURST cycles.
- Reset mid-burst: all state clears immediately, any pending rvalid is dropped, and a write in flight is not committed if reset is asserted before the clock edge.

Decomposition:
- Shared package holds:
  - owner encoding constants OWN_C=0, OWN_D=1;
  - ADDR_W and DATA_W defaults, shared with the data memory and the top level.
- One natural sub-module: rr_pick2. It is a combinational 2-way round-robin picker: inputs req[1:0], last, lock; output gnt[1:0].

Test Plan:
- Reset then idle: reset low for 2 cycles, no requests -> all outputs 0, last=D; first c_req at addr 5 -> c_gnt=1 in the same cycle.
- CPU write then read: C writes 0xDEADBEEF to addr 3, next cycle C reads addr 3 -> mem_we=1 only in the first cycle, then c_rvalid=1 with c_rdata=0xDEADBEEF one cycle after the read grant.
- Tie round-robin: c_req=d_req=1 continuously, d_lock=0 -> grants alternate C,D,C,D starting with C after reset.
- Burst lock: MAX_BURST=4, D holds d_lock with reads of addr 0..7 while C requests -> D granted 4 consecutive cycles, then C, then D resumes; each D read gives d_rvalid the next cycle.
- Simultaneous write and read: D writes 0x12345678 to addr 10 while C reads addr 10 in the same cycle -> only one grant; when C is granted on the following cycle, c_rdata=0x12345678.
- Reset mid-burst: assert reset during the 3rd locked D read -> d_rvalid=0 and burst_cnt=0 immediately; after release, a tie grants C first.
